// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw asynchronous input for the clk domain.
// A SYNC_STAGES-deep synchroniser feeds a four-state debouncer that accepts
// a new level only after DEBOUNCE_CYCLES consecutive matching samples.
// Outputs are a clean registered level with its registered complement, a busy
// flag while a change is being qualified, and optional one-cycle edge pulses.
// Optional feature macro: DEBOUNCE_EDGE_EN
//   defined   -> rise/fall pulses are generated
//   undefined -> rise/fall are tied to 0; level, complement and busy unchanged
// Parameter constraints: SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 2, and CNT_W must
// be wide enough to hold DEBOUNCE_CYCLES-1.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic doutbar,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] S_LOW    = 2'd0;
    localparam logic [1:0] S_QUAL_H = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_QUAL_L = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_doutbar;

    logic                   w_s;
    logic [1:0]             w_stateNext;
    logic [CNT_W-1:0]       w_cntNext;
    logic                   w_toHigh;
    logic                   w_toLow;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain to tame metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Next-state and counter logic; a reversal during qualification aborts it.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_toHigh    = 1'b0;
        w_toLow     = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    w_stateNext = S_QUAL_H;
                    w_cntNext   = CNT_ONE;
                end
            end
            S_QUAL_H: begin
                if (!w_s) begin
                    w_stateNext = S_LOW;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext = S_HIGH;
                    w_cntNext   = '0;
                    w_toHigh    = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    w_stateNext = S_QUAL_L;
                    w_cntNext   = CNT_ONE;
                end
            end
            S_QUAL_L: begin
                if (w_s) begin
                    w_stateNext = S_HIGH;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext = S_LOW;
                    w_cntNext   = '0;
                    w_toLow     = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = S_LOW;
                w_cntNext   = '0;
            end
        endcase
    end

    // Register state and counter; reset returns to idle-low without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // The clean level and its complement only move when a change is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= 1'b0;
            r_doutbar <= 1'b1;
        end else if (w_toHigh) begin
            r_dout    <= 1'b1;
            r_doutbar <= 1'b0;
        end else if (w_toLow) begin
            r_dout    <= 1'b0;
            r_doutbar <= 1'b1;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses are high only on the cycle right after an accepted change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_toHigh;
            r_fall <= w_toLow;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

    assign dout    = r_dout;
    assign doutbar = r_doutbar;
    assign busy    = (r_state == S_QUAL_H) || (r_state == S_QUAL_L);

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: self-checking bench for debounce_sync with default
// parameters. Per-cycle expectations come from a hand-derived vector table
// pushed into a scoreboard queue as each input is driven; asynchronous reset
// corner cases are exercised by hand-written sequences afterwards.
module tb_debounce_sync;

    typedef struct {
        bit din;
        bit dout;
        bit rise;
        bit fall;
        bit busy;
    } vec_t;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic dout;
    logic doutbar;
    logic rise;
    logic fall;
    logic busy;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecTable[$];
    vec_t expQueue[$];

    debounce_sync #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .dout(dout),
        .doutbar(doutbar),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void addRow(input bit d, input bit o, input bit r, input bit f, input bit b);
        vec_t v;
        v.din  = d;
        v.dout = o;
        v.rise = r;
        v.fall = f;
        v.busy = b;
        vecTable.push_back(v);
    endfunction

    task automatic checkOutput(input string tag);
        vec_t e;
        if (expQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s.queue: got empty scoreboard, expected an entry", tag);
        end else begin
            e = expQueue.pop_front();
            checkValue({tag, ".dout"}, dout, e.dout);
            checkValue({tag, ".doutbar"}, doutbar, ~e.dout);
            checkValue({tag, ".rise"}, rise, EDGE_EN ? e.rise : 1'b0);
            checkValue({tag, ".fall"}, fall, EDGE_EN ? e.fall : 1'b0);
            checkValue({tag, ".busy"}, busy, e.busy);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        din = v.din;
        expQueue.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkResetState(input string tag);
        checkValue({tag, ".dout"}, dout, 1'b0);
        checkValue({tag, ".doutbar"}, doutbar, 1'b1);
        checkValue({tag, ".rise"}, rise, 1'b0);
        checkValue({tag, ".fall"}, fall, 1'b0);
        checkValue({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        vec_t v;
        int riseEdge;
        bit seen;

        // Power-on: din=1 held, released from reset; dout rises at edge 6.
        addRow(1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 1, 1, 0, 0);
        addRow(1, 1, 0, 0, 0);
        addRow(1, 1, 0, 0, 0);
        // Falling edge: din=0 held from dout=1; dout falls at edge 6.
        addRow(0, 1, 0, 0, 0);
        addRow(0, 1, 0, 0, 0);
        addRow(0, 1, 0, 0, 1);
        addRow(0, 1, 0, 0, 1);
        addRow(0, 1, 0, 0, 1);
        addRow(0, 0, 0, 1, 0);
        addRow(0, 0, 0, 0, 0);
        // Glitch: din=1 for two cycles is rejected after two busy cycles.
        addRow(1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 0);
        addRow(0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0);
        addRow(0, 0, 0, 0, 0);
        // Bounce: ten toggles then settle high; one rise, six edges after.
        addRow(1, 0, 0, 0, 0);
        addRow(0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 0, 0, 0, 1);
        addRow(1, 1, 1, 0, 0);
        addRow(1, 1, 0, 0, 0);

        rst = 1'b1;
        din = 1'b1;
        #2;
        checkResetState("reset.noclock");
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetState("reset.clocked");
        #3;
        rst = 1'b0;

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset while a falling change is being qualified.
        v.din  = 1'b0;
        v.dout = 1'b1;
        v.rise = 1'b0;
        v.fall = 1'b0;
        v.busy = 1'b0;
        applyStimulus(v, "qualL.e1");
        applyStimulus(v, "qualL.e2");
        v.busy = 1'b1;
        applyStimulus(v, "qualL.e3");
        #3;
        rst = 1'b1;
        #1;
        checkResetState("asyncBusy");
        #1;
        rst = 1'b0;
        din = 1'b1;

        // Re-qualify high from reset, then reset asynchronously while dout=1.
        seen     = 1'b0;
        riseEdge = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (dout === 1'b1) begin
                seen     = 1'b1;
                riseEdge = i;
                checkValue("relatch.rise", rise, EDGE_EN);
            end
        end
        testsRun++;
        if (riseEdge != 6) begin
            testsFailed++;
            $display("[TB] FAIL relatch.latency: got edge %0d, expected edge 6", riseEdge);
        end
        #3;
        rst = 1'b1;
        #1;
        checkResetState("asyncHigh");
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
